// File: rtl/mean3x3_stream_ctrl_if.sv
// Pixel-stream handshake bundle for the 3x3 mean controller: input pixel
// stream from the source and filtered output stream to the sink.
interface mean3x3_stream_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mean3x3_stream_ctrl.sv
// 3x3 mean filter over a raster pixel stream: two line buffers, a 3x3 window
// and a two-stage valid/ready pipeline; emits interior pixels only.

// Each tap is scaled by 29/256 (1/9 rounded up) and truncated on its own,
// so a constant 255 image filters to 9*28 = 252 and the sum never overflows.
module kernel (
  input  logic [71:0] pixel_batch,
  output logic [7:0]  result
);
  always_comb begin
    result = '0;
    for (int i = 0; i < 9; i++)
      result = result + 8'((16'(pixel_batch[8*i +: 8]) * 16'd29) >> 8);
  end
endmodule

module mean3x3_stream_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic frame_done,
  mean3x3_stream_ctrl_if.slave strm
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  state_t          state;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [7:0]      lb0 [WIDTH];
  logic [7:0]      lb1 [WIDTH];
  logic [8:0][7:0] win;
  logic            win_valid;
  logic            win_last;
  logic [7:0]      kernel_out;
  logic            advance;
  logic            accept;
  logic            col_last;
  logic            row_last;

  assign advance       = !strm.out_valid || strm.out_ready;
  assign strm.in_ready = advance && (state == PRIME || state == STREAM);
  assign accept        = strm.in_valid && strm.in_ready;
  assign col_last      = (col == CW'(WIDTH - 1));
  assign row_last      = (row == RW'(HEIGHT - 1));

  kernel u_kernel (
    .pixel_batch (win),
    .result      (kernel_out)
  );

  // A start is only honoured from IDLE outside the frame_done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        IDLE: begin
          if (start && !frame_done) begin
            state <= PRIME;
            col   <= '0;
            row   <= '0;
            busy  <= 1'b1;
          end
        end
        PRIME: begin
          if (accept && row == RW'(1) && col_last)
            state <= STREAM;
        end
        STREAM: begin
          if (accept && row_last && col_last)
            state <= DRAIN;
        end
        DRAIN: begin
          if (strm.out_valid && strm.out_ready && strm.out_last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line buffers are plain storage; rows 0-1 of every frame overwrite them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= strm.in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win            <= '0;
      win_valid      <= 1'b0;
      win_last       <= 1'b0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_last  <= 1'b0;
    end else begin
      if (accept) begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= lb1[col];
        win[3] <= win[4];
        win[4] <= win[5];
        win[5] <= lb0[col];
        win[6] <= win[7];
        win[7] <= win[8];
        win[8] <= strm.in_pixel;
      end
      // Stage 1 flags the window only when its three columns share a row span.
      if (advance) begin
        win_valid      <= accept && row >= RW'(2) && col >= CW'(2);
        win_last       <= accept && row_last && col_last;
        strm.out_valid <= win_valid;
        strm.out_data  <= kernel_out;
        strm.out_last  <= win_valid && win_last;
      end
    end
  end
endmodule

// File: doc/mean3x3_stream_ctrl.md
Name: mean3x3_stream_ctrl

Overview:
- Frame-level controller that sequences the 3x3 `kernel` mean-filter datapath over a raster pixel stream.
- Holds two line buffers and a 3x3 window register set. Presents the window to an internal `kernel` instance as the 72-bit `pixel_batch`.
- Returns filtered interior pixels on a valid/ready output stream.
- Sits between the image source (DMA/camera stream) and the result writer; one frame per `start`.

Parameters:
- WIDTH, 640, pixels per line; must be >= 3.
- HEIGHT, 480, lines per frame; must be >= 3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; arms one frame when idle, ignored otherwise.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last output handshake of a frame.
- in_valid  in  1  source has a pixel.
- in_ready  out  1  controller accepts a pixel this cycle.
- in_pixel  in  8  unsigned pixel, raster order (row 0 col 0 first).
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_data  out  8  filtered pixel, 0-255.
- out_last  out  1  qualifies the final output pixel of the frame.

Behaviour:
- Reset: busy=0, frame_done=0, in_ready=0, out_valid=0, out_data=0, out_last=0. State=IDLE; col/row counters=0; window regs=0; win_valid=0. Line-buffer RAM is not reset.
- Reset mid-frame: the frame is abandoned with no frame_done. The next start begins a fresh frame.
- advance = !out_valid || out_ready. The whole pipeline holds when advance=0.
- accept = in_valid && in_ready.
- in_ready = advance && (state==PRIME || state==STREAM). It is combinational on out_ready.
- FSM:
  - IDLE: start -> PRIME; col, row cleared.
  - PRIME: accepting rows 0-1. Move to STREAM on the accept of (row 1, col WIDTH-1).
  - STREAM: accepting rows 2..HEIGHT-1. Move to DRAIN on the accept of (HEIGHT-1, WIDTH-1).
  - DRAIN: in_ready=0. Move to IDLE on the output handshake with out_last=1; frame_done=1 in that same transition cycle.
- Counters: on accept, col increments. At WIDTH-1, col wraps to 0 and row increments.
- Line buffers lb0 (previous row) and lb1 (two rows back), WIDTH x 8 each, indexed by col.
  - On accept at col c: lb1[c] <= lb0[c]; lb0[c] <= in_pixel.
  - New window column = (top lb1[c], mid lb0[c], bottom in_pixel).
- Window: on accept, the 3 columns shift left and the new column enters on the right.
  - pixel_batch packing is row-major: [7:0] top-left, [15:8] top-mid, [23:16] top-right, [31:24] mid-left, [39:32] centre, ..., [71:64] bottom-right.
- Stage 1 (on advance): win_valid <= accept && row>=2 && col>=2, sampled with the pre-increment counters.
  - The window centred at (row-1, col-1) is then complete.
  - Windows straddling a line wrap are never flagged valid. No border pixels are output.
- Stage 2 (on advance):
  - out_valid <= win_valid.
  - out_data <= kernel result on the current window.
  - out_last <= win_valid && window is the frame's last.
- Latency: accept of the completing pixel -> out_valid exactly 2 cycles later, with no backpressure.
- Throughput: 1 pixel/cycle sustained.
- Output count per frame = (WIDTH-2)*(HEIGHT-2).
- Backpressure: out_valid && !out_ready holds out_data, out_last, the window and win_valid. in_ready=0 during the hold. No loss or duplication.
- in_valid gaps: win_valid drains to 0 and no bubble data is emitted.
- start while busy or in the frame_done cycle: ignored.
- start in the cycle after frame_done: accepted.

Test Plan:
- WIDTH=4, HEIGHT=4, constant 0 image, out_ready=1 -> exactly 4 outputs of 0. out_last on the 4th; frame_done one pulse; busy falls with it.
- Same geometry, constant 255 image -> 4 outputs of 252 (truncating Q8.8 kernel). First out_valid 2 cycles after the accept of pixel (2,2).
- WIDTH=5, HEIGHT=3, ramp in_pixel = 10*col + row -> 3 outputs in order. Each equals the kernel model of its 3x3 neighbourhood. No output is produced for col 0/1 wrap windows.
- Constant-255 frame with random in_valid gaps and out_ready toggled 50% -> same 4 values. out_data stable while out_valid && !out_ready; in_ready=0 whenever out_valid && !out_ready.
- Assert rst during STREAM, then start a fresh 4x4 frame -> no frame_done from the aborted frame; the new frame yields exactly 4 correct outputs.
- start pulsed while busy, and in_valid held high while IDLE -> no state change and in_ready=0 until the next start from IDLE.
